// File: rtl/la_iopwrseq_pkg.sv
// Shared types and constants for the pad-ring power sequencer.
package la_iopwrseq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RING     = 3'd2,
    ST_HOLDREL  = 3'd3,
    ST_INEN     = 3'd4,
    ST_READY    = 3'd5,
    ST_SHUTDOWN = 3'd6
  } state_e;

  // Shutdown drop points, in units of STEPN cycles after SHUTDOWN entry:
  // ie drops at step 1, hld_n at step 2, enable_h (and return to OFF) at step 3.
  localparam int unsigned SD_IE_STEP  = 1;
  localparam int unsigned SD_HLD_STEP = 2;
  localparam int unsigned SD_EN_STEP  = 3;

endpackage

// File: rtl/la_iopwrseq_sync.sv
// Two-flop synchronizer for an asynchronous supply-good indication.
module la_iopwrseq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages clear to 0 so a supply is "bad" until proven good.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/la_iopwrseq.sv
// Power-on / power-down sequencer for the io pad ring enables.
//
// state       | meaning
// ------------+---------------------------------------------------------
// OFF         | all ring controls off, waiting for both supplies good
// DEBOUNCE    | supplies good, counting DEBN stable cycles
// RING        | enable_h on
// HOLDREL     | enable_h on, hold released (hld_n=1)
// INEN        | enable_h, hld_n and ie on
// READY       | everything on, core may drive outputs, pwr_good=1
// SHUTDOWN    | controls drop in reverse order, one every STEPN cycles
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter int unsigned DEBN  = 16,
  parameter int unsigned STEPN = 32,
  parameter int unsigned CNTW  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vdd_ok,
  input  logic       vddio_ok,
  input  logic       req_off,
  output logic       enable_h,
  output logic       hld_n,
  output logic       ie,
  output logic       oe_ok,
  output logic       pwr_good,
  output logic [2:0] state
);

  localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBN - 1);
  localparam logic [CNTW-1:0] STEP_LAST = CNTW'(STEPN - 1);
  localparam logic [CNTW-1:0] SD_IE     = CNTW'(SD_IE_STEP * STEPN);
  localparam logic [CNTW-1:0] SD_HLD    = CNTW'(SD_HLD_STEP * STEPN);
  localparam logic [CNTW-1:0] SD_LAST   = CNTW'(SD_EN_STEP * STEPN - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;

  logic            vdd_s, vddio_s, sup_ok;
  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            en_d, hld_d, ie_d, oe_d, pg_d;

  la_iopwrseq_sync u_sync_vdd (
    .clk   (clk),
    .reset (reset),
    .d     (vdd_ok),
    .q     (vdd_s)
  );

  la_iopwrseq_sync u_sync_vddio (
    .clk   (clk),
    .reset (reset),
    .d     (vddio_ok),
    .q     (vddio_s)
  );

  assign sup_ok  = vdd_s & vddio_s;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Next state and counter; the counter clears on every state change except a
  // mid-ramp supply loss, which enters SHUTDOWN at the drop point matching the
  // controls already on so nothing rises during shutdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_OFF: begin
        if (sup_ok && !req_off) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!sup_ok)                state_d = ST_OFF;
        else if (cnt_q == DEB_LAST) state_d = ST_RING;
        else                        cnt_d   = cnt_inc;
      end
      ST_RING: begin
        if (!sup_ok) begin
          state_d = ST_SHUTDOWN;
          cnt_d   = SD_HLD;
        end else if (cnt_q == STEP_LAST) begin
          state_d = ST_HOLDREL;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_HOLDREL: begin
        if (!sup_ok) begin
          state_d = ST_SHUTDOWN;
          cnt_d   = SD_IE;
        end else if (cnt_q == STEP_LAST) begin
          state_d = ST_INEN;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_INEN: begin
        if (!sup_ok)                 state_d = ST_SHUTDOWN;
        else if (cnt_q == STEP_LAST) state_d = ST_READY;
        else                         cnt_d   = cnt_inc;
      end
      ST_READY: begin
        if (req_off || !sup_ok) state_d = ST_SHUTDOWN;
      end
      ST_SHUTDOWN: begin
        if (cnt_q == SD_LAST) state_d = ST_OFF;
        else                  cnt_d   = cnt_inc;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Output decode from the next state so outputs move with the state register.
  always_comb begin
    en_d  = 1'b0;
    hld_d = 1'b0;
    ie_d  = 1'b0;
    oe_d  = 1'b0;
    pg_d  = 1'b0;
    case (state_d)
      ST_RING: begin
        en_d  = 1'b1;
      end
      ST_HOLDREL: begin
        en_d  = 1'b1;
        hld_d = 1'b1;
      end
      ST_INEN: begin
        en_d  = 1'b1;
        hld_d = 1'b1;
        ie_d  = 1'b1;
      end
      ST_READY: begin
        en_d  = 1'b1;
        hld_d = 1'b1;
        ie_d  = 1'b1;
        oe_d  = 1'b1;
        pg_d  = 1'b1;
      end
      ST_SHUTDOWN: begin
        en_d  = 1'b1;
        hld_d = (cnt_d < SD_HLD);
        ie_d  = (cnt_d < SD_IE);
      end
      default: ;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      enable_h <= 1'b0;
      hld_n    <= 1'b0;
      ie       <= 1'b0;
      oe_ok    <= 1'b0;
      pwr_good <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_h <= en_d;
      hld_n    <= hld_d;
      ie       <= ie_d;
      oe_ok    <= oe_d;
      pwr_good <= pg_d;
    end
  end

  assign state = state_q;

endmodule
